// File: rtl/slap_pkg.sv
// slap_line shared package: depth floor and counter width helper.
// Optional feature macro used by slap_line: SLAP_EDGE_EN.
package slap_pkg;

    localparam int SLAP_MIN_DEPTH = 2;

    // Bits needed to count 0..depth valid stages.
    function automatic int slap_occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/slap_stage.sv
// slap_stage: one valid+data register of the delay line.
// Priority on each edge is rst, then flush, then en, else hold.
module slap_stage
    import slap_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Flush clears only the valid bit; data stays as it was.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/slap_line.sv
// slap_line: registered delay line with tap, occupancy and rise detect.
// Define SLAP_EDGE_EN to build the out_data rising-edge detector.
module slap_line
    import slap_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(DEPTH)-1:0]   tap_sel,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       tap_valid,
    output logic [WIDTH-1:0]           tap_data,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic [WIDTH-1:0]           edge_rise
);

    localparam int SW = $clog2(DEPTH);
    localparam int OW = slap_occ_w(DEPTH);

    if (DEPTH < SLAP_MIN_DEPTH) begin : g_depth_chk
        $error("slap_line: DEPTH must be at least %0d", SLAP_MIN_DEPTH);
    end

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } slap_stage_t;

    slap_stage_t stg [DEPTH];
    slap_stage_t nxt [DEPTH];

    // Stage 0 takes the input; every later stage takes its predecessor.
    always_comb begin
        nxt[0] = '{valid: in_valid, data: in_data};
        for (int k = 1; k < DEPTH; k++) begin
            nxt[k] = stg[k-1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        slap_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk_i   (clk),
            .rst_i   (rst),
            .flush_i (flush),
            .en_i    (en),
            .valid_i (nxt[k].valid),
            .data_i  (nxt[k].data),
            .valid_o (stg[k].valid),
            .data_o  (stg[k].data)
        );
    end

    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;

    // One in, one out per advance; the count tracks the difference.
    always_comb begin
        occ_d = occ_q;
        if (en) begin
            occ_d = occ_q + OW'(in_valid) - OW'(stg[DEPTH-1].valid);
        end
    end

    // Occupancy register shares the stage reset/flush priority.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Tap mux reads stage registers only; out-of-range selects give zero.
    always_comb begin
        tap_valid = 1'b0;
        tap_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_sel == SW'(k)) begin
                tap_valid = stg[k].valid;
                tap_data  = stg[k].data;
            end
        end
    end

    assign out_valid = stg[DEPTH-1].valid;
    assign out_data  = stg[DEPTH-1].data;
    assign occ       = occ_q;

`ifdef SLAP_EDGE_EN
    logic [WIDTH-1:0] h_q;

    // History holds the out_data seen just before the last advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= RST_VAL;
        end else if (!flush && en) begin
            h_q <= out_data;
        end
    end

    assign edge_rise = out_valid ? (out_data & ~h_q) : '0;
`else
    assign edge_rise = '0;
`endif

endmodule
